// File: rtl/bmm150_pkg.sv
// Shared constants, FSM state encoding and sample payload for the BMM150 sequencer.
package bmm150_pkg;

  localparam logic [6:0] CHIP_ID_REG = 7'h40;
  localparam logic [6:0] DATA_BASE   = 7'h42;
  localparam logic [6:0] PWR_CTRL    = 7'h4B;
  localparam logic [6:0] OPMODE_REG  = 7'h4C;
  localparam logic [7:0] PWR_ON_VAL  = 8'h01;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ID      = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_PWR_ON,
    ST_STARTUP,
    ST_READ_ID,
    ST_SET_MODE,
    ST_SAMPLE_WAIT,
    ST_READ_DATA,
    ST_PUBLISH,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [12:0] mag_x;
    logic [12:0] mag_y;
    logic [14:0] mag_z;
    logic [13:0] rhall;
    logic        drdy;
  } mag_sample_t;

  // b[i] is the byte read from DATA_BASE+i; low bits of each LSB register are flags/padding.
  function automatic mag_sample_t assemble(input logic [7:0][7:0] b);
    mag_sample_t s;
    s.mag_x = {b[1], b[0][7:3]};
    s.mag_y = {b[3], b[2][7:3]};
    s.mag_z = {b[5], b[4][7:1]};
    s.rhall = {b[7], b[6][7:2]};
    s.drdy  = b[6][0];
    return s;
  endfunction

endpackage

// File: rtl/bmm150_spi_xfer.sv
// One SPI-master transaction: issue a start pulse, track busy high then low, time out any stalled phase.
module bmm150_spi_xfer #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] tx_i,
  input  logic       spi_busy_i,
  input  logic [7:0] spi_rx_i,
  output logic       spi_start_o,
  output logic       spi_rw_o,
  output logic [6:0] spi_addr_o,
  output logic [7:0] spi_tx_o,
  output logic       ack_o,
  output logic [7:0] rx_o,
  output logic       timeout_o
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] X_IDLE    = 2'd0;
  localparam logic [1:0] X_ISSUE   = 2'd1;
  localparam logic [1:0] X_WAIT_HI = 2'd2;
  localparam logic [1:0] X_WAIT_LO = 2'd3;

  logic [1:0]    st_q, st_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          rw_q, rw_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    tx_q, tx_d;
  logic          ack_q, ack_d;
  logic [7:0]    rx_q, rx_d;
  logic          to_q, to_d;
  logic          at_limit_c;

  assign at_limit_c = (cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    ack_d   = 1'b0;
    rx_d    = rx_q;
    to_d    = 1'b0;
    case (st_q)
      X_IDLE: begin
        if (req_i) begin
          rw_d   = rw_i;
          addr_d = addr_i;
          tx_d   = tx_i;
          cnt_d  = '0;
          st_d   = X_ISSUE;
        end
      end
      X_ISSUE: begin
        if (!spi_busy_i) begin
          start_d = 1'b1;
          cnt_d   = '0;
          st_d    = X_WAIT_HI;
        end else if (at_limit_c) begin
          to_d = 1'b1;
          st_d = X_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      X_WAIT_HI: begin
        if (spi_busy_i) begin
          cnt_d = '0;
          st_d  = X_WAIT_LO;
        end else if (at_limit_c) begin
          to_d = 1'b1;
          st_d = X_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      X_WAIT_LO: begin
        // Read data is valid in the same cycle busy drops.
        if (!spi_busy_i) begin
          rx_d  = spi_rx_i;
          ack_d = 1'b1;
          st_d  = X_IDLE;
        end else if (at_limit_c) begin
          to_d = 1'b1;
          st_d = X_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= X_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      tx_q    <= '0;
      ack_q   <= 1'b0;
      rx_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      rx_q    <= rx_d;
      to_q    <= to_d;
    end
  end

  assign spi_start_o = start_q;
  assign spi_rw_o    = rw_q;
  assign spi_addr_o  = addr_q;
  assign spi_tx_o    = tx_q;
  assign ack_o       = ack_q;
  assign rx_o        = rx_q;
  assign timeout_o   = to_q;

endmodule

// File: rtl/bmm150_ctrl.sv
// BMM150 sequencer: power-up, chip-ID check, normal mode, then periodic 8-byte data reads.
module bmm150_ctrl
  import bmm150_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SAMPLE_HZ   = 10,
  parameter int unsigned STARTUP_US  = 3000,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [7:0]  CHIP_ID     = 8'h32,
  parameter logic [7:0]  OPMODE_VAL  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  output logic        spi_enable,
  output logic        spi_start,
  output logic        spi_rw,
  output logic [6:0]  spi_addr,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_busy,
  output logic        init_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [12:0] mag_x,
  output logic [12:0] mag_y,
  output logic [14:0] mag_z,
  output logic [13:0] rhall,
  output logic        drdy,
  output logic        data_valid
);

  localparam int unsigned P  = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned W  = (CLK_HZ / 1_000_000) * STARTUP_US;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned WW = (W > 1) ? $clog2(W) : 1;

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic            rst_pend_q, rst_pend_d;
  logic [2:0]      idx_q, idx_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [PW-1:0]   tcnt_q, tcnt_d;
  logic [7:0][7:0] buf_q, buf_d;
  logic            init_done_q, init_done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  mag_sample_t     sample_q, sample_d;
  logic            data_valid_q, data_valid_d;
  logic            spi_enable_q;

  logic            req_c, rw_c, txn_c, tick_c, xfer_free_c;
  logic [6:0]      addr_c;
  logic [7:0]      tx_c;
  logic            xfer_ack, xfer_to;
  logic [7:0]      xfer_rx;

  bmm150_spi_xfer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_xfer (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_c),
    .rw_i        (rw_c),
    .addr_i      (addr_c),
    .tx_i        (tx_c),
    .spi_busy_i  (spi_busy),
    .spi_rx_i    (spi_rx),
    .spi_start_o (spi_start),
    .spi_rw_o    (spi_rw),
    .spi_addr_o  (spi_addr),
    .spi_tx_o    (spi_tx),
    .ack_o       (xfer_ack),
    .rx_o        (xfer_rx),
    .timeout_o   (xfer_to)
  );

  assign tick_c      = init_done_q && (tcnt_q == PW'(P - 1));
  assign xfer_free_c = !pend_q || xfer_ack || xfer_to;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    rst_pend_d   = rst_pend_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    buf_d        = buf_q;
    init_done_d  = init_done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    sample_d     = sample_q;
    data_valid_d = 1'b0;
    req_c        = 1'b0;
    rw_c         = 1'b0;
    addr_c       = '0;
    tx_c         = '0;
    txn_c        = 1'b0;
    tcnt_d       = init_done_q ? (tick_c ? '0 : tcnt_q + PW'(1)) : '0;

    // Restart waits for any in-flight transaction to end, and beats a coincident tick.
    if ((restart || rst_pend_q) && xfer_free_c) begin
      state_d     = ST_PWR_ON;
      pend_d      = 1'b0;
      rst_pend_d  = 1'b0;
      wcnt_d      = '0;
      init_done_d = 1'b0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
    end else begin
      if (restart) rst_pend_d = 1'b1;
      if (xfer_ack || xfer_to) pend_d = 1'b0;
      if (xfer_to) begin
        state_d    = ST_ERROR;
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end else begin
        case (state_q)
          ST_PWR_ON: begin
            txn_c  = 1'b1;
            addr_c = PWR_CTRL;
            tx_c   = PWR_ON_VAL;
            if (xfer_ack) state_d = ST_STARTUP;
          end
          ST_STARTUP: begin
            if (wcnt_q == WW'(W - 1)) begin
              wcnt_d  = '0;
              state_d = ST_READ_ID;
            end else begin
              wcnt_d = wcnt_q + WW'(1);
            end
          end
          ST_READ_ID: begin
            txn_c  = 1'b1;
            rw_c   = 1'b1;
            addr_c = CHIP_ID_REG;
            if (xfer_ack) begin
              if (xfer_rx == CHIP_ID) begin
                state_d = ST_SET_MODE;
              end else begin
                state_d    = ST_ERROR;
                err_d      = 1'b1;
                err_code_d = ERR_ID;
              end
            end
          end
          ST_SET_MODE: begin
            txn_c  = 1'b1;
            addr_c = OPMODE_REG;
            tx_c   = OPMODE_VAL;
            if (xfer_ack) begin
              init_done_d = 1'b1;
              state_d     = ST_SAMPLE_WAIT;
            end
          end
          ST_SAMPLE_WAIT: begin
            if (tick_c) begin
              idx_d   = '0;
              state_d = ST_READ_DATA;
            end
          end
          ST_READ_DATA: begin
            txn_c  = 1'b1;
            rw_c   = 1'b1;
            addr_c = DATA_BASE + 7'(idx_q);
            if (xfer_ack) begin
              buf_d[idx_q] = xfer_rx;
              if (idx_q == 3'd7) state_d = ST_PUBLISH;
              else               idx_d   = idx_q + 3'd1;
            end
          end
          ST_PUBLISH: begin
            sample_d     = assemble(buf_q);
            data_valid_d = 1'b1;
            state_d      = ST_SAMPLE_WAIT;
          end
          ST_ERROR: ;
        endcase
        if (txn_c && !pend_q) begin
          req_c  = 1'b1;
          pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PWR_ON;
      pend_q       <= 1'b0;
      rst_pend_q   <= 1'b0;
      idx_q        <= '0;
      wcnt_q       <= '0;
      tcnt_q       <= '0;
      buf_q        <= '0;
      init_done_q  <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      sample_q     <= '0;
      data_valid_q <= 1'b0;
      spi_enable_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      rst_pend_q   <= rst_pend_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      tcnt_q       <= tcnt_d;
      buf_q        <= buf_d;
      init_done_q  <= init_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      sample_q     <= sample_d;
      data_valid_q <= data_valid_d;
      spi_enable_q <= 1'b1;
    end
  end

  assign spi_enable = spi_enable_q;
  assign init_done  = init_done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign mag_x      = sample_q.mag_x;
  assign mag_y      = sample_q.mag_y;
  assign mag_z      = sample_q.mag_z;
  assign rhall      = sample_q.rhall;
  assign drdy       = sample_q.drdy;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_bmm150_ctrl.sv
// Scoreboard bench for bmm150_ctrl: expected SPI transactions and samples are queued by the stimulus, popped by a monitor.
module tb_bmm150_ctrl;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned SAMPLE_HZ  = 50;
  localparam int unsigned STARTUP_US = 50;
  localparam int unsigned TO_CYC     = 64;
  localparam int P = 20000;
  localparam int W = 50;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] tx;
  } txn_t;

  typedef struct packed {
    logic [12:0] x;
    logic [12:0] y;
    logic [14:0] z;
    logic [13:0] rh;
    logic        dr;
  } smp_t;

  logic        clk, rst_n, restart;
  logic        spi_enable, spi_start, spi_rw, spi_busy;
  logic [6:0]  spi_addr;
  logic [7:0]  spi_tx, spi_rx;
  logic        init_done, err, data_valid, drdy;
  logic [1:0]  err_code;
  logic [12:0] mag_x, mag_y;
  logic [14:0] mag_z;
  logic [13:0] rhall;

  bmm150_ctrl #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .STARTUP_US(STARTUP_US),
    .TIMEOUT_CYC(TO_CYC), .CHIP_ID(8'h32), .OPMODE_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .spi_enable(spi_enable), .spi_start(spi_start), .spi_rw(spi_rw),
    .spi_addr(spi_addr), .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_busy(spi_busy),
    .init_done(init_done), .err(err), .err_code(err_code),
    .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z), .rhall(rhall),
    .drdy(drdy), .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  txn_t exp_txn[$];
  smp_t exp_smp[$];
  logic [7:0] mem [0:127];
  logic stuck = 1'b0;
  logic seen45 = 1'b0;
  int   last_4b = 0, last_40 = 0, last_start = 0, prev_dv = -1, dv_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_w(input logic [6:0] a, input logic [7:0] d);
    exp_txn.push_back('{rw: 1'b0, addr: a, tx: d});
  endfunction

  function automatic void push_r(input logic [6:0] a);
    exp_txn.push_back('{rw: 1'b1, addr: a, tx: 8'h00});
  endfunction

  function automatic void push_burst();
    for (int i = 0; i < 8; i++) push_r(7'(8'h42 + i));
  endfunction

  // SPI master stand-in: busy rises two cycles after start, stays high four cycles.
  int         m_cnt;
  logic       m_rw;
  logic [6:0] m_addr;
  initial begin
    spi_busy = 1'b0; spi_rx = 8'h00; m_cnt = 0; m_rw = 1'b0; m_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_cnt = 0; spi_busy = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 4) begin
          spi_busy = 1'b1;
          spi_rx   = m_rw ? mem[m_addr] : 8'h00;
        end else if (m_cnt == 0) begin
          spi_busy = 1'b0;
        end
      end else if (spi_start && !stuck) begin
        m_cnt = 6; m_rw = spi_rw; m_addr = spi_addr;
      end
    end
  end

  // Monitor: pops expected transactions on spi_start and expected samples on data_valid.
  initial begin
    txn_t t;
    smp_t s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_dv = -1;
      end else begin
        if (spi_start) begin
          last_start = cyc;
          if (exp_txn.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_start: got rw=%0d addr=0x%0h expected none (cycle %0d)", spi_rw, spi_addr, cyc);
          end else begin
            t = exp_txn.pop_front();
            chk("txn_rw", 32'(spi_rw), 32'(t.rw));
            chk("txn_addr", 32'(spi_addr), 32'(t.addr));
            if (!t.rw) chk("txn_tx", 32'(spi_tx), 32'(t.tx));
          end
          if (spi_addr == 7'h4B) last_4b = cyc;
          if (spi_addr == 7'h40) last_40 = cyc;
          if (spi_addr == 7'h45 && spi_rw) seen45 = 1'b1;
        end
        if (data_valid) begin
          if (exp_smp.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_valid: got data_valid=1 expected none (cycle %0d)", cyc);
          end else begin
            s = exp_smp.pop_front();
            chk("mag_x", 32'(mag_x), 32'(s.x));
            chk("mag_y", 32'(mag_y), 32'(s.y));
            chk("mag_z", 32'(mag_z), 32'(s.z));
            chk("rhall", 32'(rhall), 32'(s.rh));
            chk("drdy", 32'(drdy), 32'(s.dr));
          end
          if (prev_dv >= 0) chk("dv_spacing", 32'(cyc - prev_dv), 32'(P));
          prev_dv = cyc;
          dv_count++;
        end
      end
    end
  end

  function automatic void load_data(input logic [63:0] bytes);
    for (int i = 0; i < 8; i++) mem[8'h42 + i] = bytes[63 - 8*i -: 8];
  endfunction

  initial begin
    int err_cyc;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    rst_n = 1'b0; restart = 1'b0;
    load_data(64'hF8FF0800FE7F0580);
    repeat (3) @(negedge clk);
    chk("rst_spi_enable", 32'(spi_enable), 32'd1);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_mag_x", 32'(mag_x), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);

    // Wrong chip ID: error, then silence on the bus.
    mem[8'h40] = 8'h00;
    push_w(7'h4B, 8'h01); push_r(7'h40);
    rst_n = 1'b1;
    for (int i = 0; i < 1000 && !err; i++) @(negedge clk);
    chk("id_err", 32'(err), 32'd1);
    chk("id_err_code", 32'(err_code), 32'd1);
    chk("id_init_done", 32'(init_done), 32'd0);
    repeat (100) @(negedge clk);

    // Restart with the right ID: full init sequence.
    mem[8'h40] = 8'h32;
    push_w(7'h4B, 8'h01); push_r(7'h40); push_w(7'h4C, 8'h00);
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    for (int i = 0; i < 1000 && !init_done; i++) @(negedge clk);
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_err", 32'(err), 32'd0);
    chk("init_err_code", 32'(err_code), 32'd0);
    // Write completes 10 cycles after its start; the ID-read start follows W idle cycles later.
    chk("startup_gap", 32'(last_40 - last_4b), 32'(W + 10));

    // Two sample bursts, different data each time.
    push_burst(); push_burst();
    exp_smp.push_back('{x: 13'h1FFF, y: 13'h0001, z: 15'h3FFF, rh: 14'h2001, dr: 1'b1});
    exp_smp.push_back('{x: 13'h1000, y: 13'h0FFF, z: 15'h4000, rh: 14'h3FFF, dr: 1'b0});
    for (int i = 0; i < 25000 && dv_count < 1; i++) @(negedge clk);
    chk("dv_count1", 32'(dv_count), 32'd1);
    load_data(64'h0080F87F0180FEFF);
    for (int i = 0; i < 25000 && dv_count < 2; i++) @(negedge clk);
    chk("dv_count2", 32'(dv_count), 32'd2);
    chk("hold_mag_x", 32'(mag_x), 32'h1000);

    // Reset in the middle of the 0x45 read.
    seen45 = 1'b0;
    push_burst();
    for (int i = 0; i < 25000 && !seen45; i++) @(negedge clk);
    chk("seen_0x45", 32'(seen45), 32'd1);
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 32'(spi_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_spi_start", 32'(spi_start), 32'd0);
    chk("mid_rst_mag_x", 32'(mag_x), 32'd0);
    chk("mid_rst_rhall", 32'(rhall), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    chk("mid_rst_spi_enable", 32'(spi_enable), 32'd1);
    exp_txn.delete();
    repeat (3) @(negedge clk);
    push_w(7'h4B, 8'h01); push_r(7'h40); push_w(7'h4C, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 1000 && !init_done; i++) @(negedge clk);
    chk("reinit_done", 32'(init_done), 32'd1);
    chk("reinit_startup_gap", 32'(last_40 - last_4b), 32'(W + 10));

    // Busy never rises: timeout in the first wait phase of the power-on write.
    stuck = 1'b1;
    push_w(7'h4B, 8'h01);
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 500 && !err; i++) @(negedge clk);
    err_cyc = cyc;
    chk("to_err", 32'(err), 32'd1);
    chk("to_err_code", 32'(err_code), 32'd2);
    chk("to_latency", 32'(err_cyc - last_start), 32'(TO_CYC + 1));
    chk("to_init_done", 32'(init_done), 32'd0);
    repeat (200) @(negedge clk);

    chk("txn_queue_empty", 32'(exp_txn.size()), 32'd0);
    chk("smp_queue_empty", 32'(exp_smp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
